// File: rtl/memory_access_stage_pkg.sv
// Shared types for the memory-access stage: micro-op memory fields, packet layout,
// trap causes and the stage FSM encoding.
// Pure type/constant package; no logic, no latency, no flow control.
package memory_access_stage_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } mem_op_e;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_e;

  // Encodings follow the RISC-V mcause exception numbering.
  typedef enum logic [3:0] {
    INST_ADDR_MISALIGNED  = 4'd0,
    ILLEGAL_INST          = 4'd2,
    BREAKPOINT            = 4'd3,
    LOAD_ADDR_MISALIGNED  = 4'd4,
    STORE_ADDR_MISALIGNED = 4'd6
  } trap_cause_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ       = 3'd1,
    WAIT      = 3'd2,
    RESP      = 3'd3,
    REQ_DROP  = 3'd4,
    WAIT_DROP = 3'd5
  } mem_stage_state_e;

  typedef struct packed {
    mem_op_e   mem_op;
    mem_size_e mem_size;
    logic      mem_unsigned;
    logic      rd_we;
    logic [4:0] rd;
  } uop_st;

  typedef struct packed {
    word_t r_data_1;
    word_t r_data_2;
  } regfile_r_resp_st;

  typedef struct packed {
    logic        valid;
    trap_cause_e cause;
    word_t       tval;
  } trap_st;

  typedef struct packed {
    word_t            pc;
    uop_st            uop;
    regfile_r_resp_st regfile_r_resp;
    word_t            alu_result;
    word_t            load_data;
    trap_st           trap;
  } inst_packet_st;

  function automatic logic is_mem_op(input mem_op_e op);
    return (op == LOAD) || (op == STORE);
  endfunction

endpackage

// File: rtl/inst_packet_if.sv
// Valid/ready channel carrying one instruction packet between pipeline stages.
// No storage, zero latency; transfer happens on a cycle where valid && ready.
// Modport in: consumer side (drives ready). Modport out: producer side (drives valid, packet).
interface inst_packet_if;

  logic                                  valid;
  logic                                  ready;
  memory_access_stage_pkg::inst_packet_st inst_packet;

  modport in  (input  valid, input  inst_packet, output ready);
  modport out (output valid, output inst_packet, input  ready);

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data bus: store replication + byte enables, load
// extraction + sign/zero extension, and alignment check. Purely combinational,
// no backpressure.
// Ports: i_addr_lo (addr[1:0]), i_size, i_unsigned, i_store_data, i_rdata ->
//        o_wdata, o_be, o_load_data, o_misaligned.
module mem_lane_align
  import memory_access_stage_pkg::*;
(
  input  logic [1:0] i_addr_lo,
  input  mem_size_e  i_size,
  input  logic       i_unsigned,
  input  word_t      i_store_data,
  input  word_t      i_rdata,
  output word_t      o_wdata,
  output logic [3:0] o_be,
  output word_t      o_load_data,
  output logic       o_misaligned
);

  word_t w_shifted;

  // Bring the addressed byte lane down to bit 0 before truncation.
  assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

  always_comb begin
    o_wdata      = i_store_data;
    o_be         = 4'b1111;
    o_load_data  = w_shifted;
    o_misaligned = 1'b0;
    case (i_size)
      BYTE: begin
        o_wdata     = {4{i_store_data[7:0]}};
        o_be        = 4'b0001 << i_addr_lo;
        o_load_data = {{24{w_shifted[7] & ~i_unsigned}}, w_shifted[7:0]};
      end
      HALF: begin
        o_wdata      = {2{i_store_data[15:0]}};
        o_be         = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_load_data  = {{16{w_shifted[15] & ~i_unsigned}}, w_shifted[15:0]};
        o_misaligned = i_addr_lo[0];
      end
      default: begin
        o_misaligned = |i_addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// Memory-access pipeline stage: issues one data-bus transaction at a time and
// forwards packets to writeback through a one-entry output register.
// Latency: pass-through 1 cycle; memory op 3 cycles with immediate gnt and rvalid one cycle later.
// Backpressure: execute ready only in IDLE with the output slot free or draining and no stall.
// Ports: i_clk, i_rst (sync, active-high), i_flush, i_stall, if_execute_in, if_writeback_out,
//        o_dmem_req/we/addr/wdata/be, i_dmem_gnt, i_dmem_rvalid, i_dmem_rdata.
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int XLEN = 32  // must equal $bits(word_t)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_stall,
  inst_packet_if.in       if_execute_in,
  inst_packet_if.out      if_writeback_out,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [XLEN-1:0] o_dmem_wdata,
  output logic [3:0]      o_dmem_be,
  input  logic            i_dmem_gnt,
  input  logic            i_dmem_rvalid,
  input  logic [XLEN-1:0] i_dmem_rdata
);

  mem_stage_state_e r_state;
  mem_stage_state_e w_state_next;

  inst_packet_st r_work;
  inst_packet_st r_out;
  logic          r_out_valid;

  inst_packet_st w_in_pkt;
  inst_packet_st w_pass_pkt;
  inst_packet_st w_resp_pkt;
  inst_packet_st w_out_dat;
  inst_packet_st w_work_dat;
  logic          w_out_load;
  logic          w_work_load;
  logic          w_out_valid_next;

  logic w_in_hs;
  logic w_out_hs;
  logic w_out_free;
  logic w_in_is_mem;
  logic w_accept_mem;
  logic w_accept_pass;

  logic [1:0] w_al_addr_lo;
  mem_size_e  w_al_size;
  logic       w_al_unsigned;
  word_t      w_al_wdata;
  logic [3:0] w_al_be;
  word_t      w_al_load_data;
  logic       w_al_misaligned;

  assign w_in_pkt = if_execute_in.inst_packet;

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  assign w_out_hs   = r_out_valid && if_writeback_out.ready;
  assign w_out_free = !r_out_valid || w_out_hs;

  assign if_execute_in.ready = (r_state == IDLE) && w_out_free && !i_stall;
  assign w_in_hs             = if_execute_in.valid && if_execute_in.ready;

  assign w_in_is_mem   = is_mem_op(w_in_pkt.uop.mem_op);
  assign w_accept_mem  = w_in_hs && w_in_is_mem && !w_al_misaligned;
  assign w_accept_pass = w_in_hs && !(w_in_is_mem && !w_al_misaligned);

  // ---------------------------------------------------------------------------
  // Lane aligner. In IDLE it looks at the incoming packet (only the alignment
  // check matters there, the bus is idle); otherwise at the held work packet,
  // which keeps the bus fields stable while req waits for gnt.
  // ---------------------------------------------------------------------------
  assign w_al_addr_lo  = (r_state == IDLE) ? w_in_pkt.alu_result[1:0] : r_work.alu_result[1:0];
  assign w_al_size     = (r_state == IDLE) ? w_in_pkt.uop.mem_size    : r_work.uop.mem_size;
  assign w_al_unsigned = (r_state == IDLE) ? w_in_pkt.uop.mem_unsigned : r_work.uop.mem_unsigned;

  mem_lane_align u_lane_align (
    .i_addr_lo    (w_al_addr_lo),
    .i_size       (w_al_size),
    .i_unsigned   (w_al_unsigned),
    .i_store_data (r_work.regfile_r_resp.r_data_2),
    .i_rdata      (i_dmem_rdata),
    .o_wdata      (w_al_wdata),
    .o_be         (w_al_be),
    .o_load_data  (w_al_load_data),
    .o_misaligned (w_al_misaligned)
  );

  assign o_dmem_we    = (r_work.uop.mem_op == STORE);
  assign o_dmem_addr  = {r_work.alu_result[XLEN-1:2], 2'b00};
  assign o_dmem_wdata = w_al_wdata;
  assign o_dmem_be    = w_al_be;

  // Packet leaving without a bus access; a misaligned memory op picks up its trap here.
  always_comb begin
    w_pass_pkt = w_in_pkt;
    if (w_in_is_mem && w_al_misaligned) begin
      w_pass_pkt.trap.valid = 1'b1;
      w_pass_pkt.trap.cause = (w_in_pkt.uop.mem_op == STORE) ? STORE_ADDR_MISALIGNED
                                                            : LOAD_ADDR_MISALIGNED;
      w_pass_pkt.trap.tval  = w_in_pkt.alu_result;
    end
  end

  // Completed work packet; stores leave load_data untouched and ignore rdata.
  always_comb begin
    w_resp_pkt = r_work;
    if (r_work.uop.mem_op == LOAD) begin
      w_resp_pkt.load_data = w_al_load_data;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_out_valid <= w_out_valid_next;
    end
  end

  // Packet payload registers carry no reset; only the valid/state bits matter.
  always_ff @(posedge i_clk) begin
    if (w_work_load) begin
      r_work <= w_work_dat;
    end
    if (w_out_load) begin
      r_out <= w_out_dat;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    if (i_flush) begin
      // A request already on the bus must still be granted and answered;
      // the drop states absorb that without forwarding anything.
      case (r_state)
        IDLE, RESP:      w_state_next = IDLE;
        REQ, REQ_DROP:   w_state_next = i_dmem_gnt ? WAIT_DROP : REQ_DROP;
        WAIT, WAIT_DROP: w_state_next = i_dmem_rvalid ? IDLE : WAIT_DROP;
        default:         w_state_next = IDLE;
      endcase
    end else begin
      case (r_state)
        IDLE:      if (w_accept_mem)  w_state_next = REQ;
        REQ:       if (i_dmem_gnt)    w_state_next = WAIT;
        WAIT:      if (i_dmem_rvalid) w_state_next = w_out_free ? IDLE : RESP;
        RESP:      if (w_out_free)    w_state_next = IDLE;
        REQ_DROP:  if (i_dmem_gnt)    w_state_next = WAIT_DROP;
        WAIT_DROP: if (i_dmem_rvalid) w_state_next = IDLE;
        default:                      w_state_next = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and register load enables
  // ---------------------------------------------------------------------------
  always_comb begin
    o_dmem_req       = (r_state == REQ) || (r_state == REQ_DROP);
    w_out_load       = 1'b0;
    w_out_dat        = w_pass_pkt;
    w_work_load      = 1'b0;
    w_work_dat       = w_in_pkt;
    w_out_valid_next = r_out_valid && !w_out_hs;
    if (i_flush) begin
      w_out_valid_next = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept_mem) begin
            w_work_load = 1'b1;
            w_work_dat  = w_in_pkt;
          end else if (w_accept_pass) begin
            w_out_load       = 1'b1;
            w_out_dat        = w_pass_pkt;
            w_out_valid_next = 1'b1;
          end
        end
        WAIT: begin
          // The accept rule normally leaves the output slot empty by the time
          // the response returns; RESP only covers the case where it is not.
          if (i_dmem_rvalid) begin
            if (w_out_free) begin
              w_out_load       = 1'b1;
              w_out_dat        = w_resp_pkt;
              w_out_valid_next = 1'b1;
            end else begin
              w_work_load = 1'b1;
              w_work_dat  = w_resp_pkt;
            end
          end
        end
        RESP: begin
          if (w_out_free) begin
            w_out_load       = 1'b1;
            w_out_dat        = r_work;
            w_out_valid_next = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign if_writeback_out.valid       = r_out_valid;
  assign if_writeback_out.inst_packet = r_out;

endmodule

// File: tb/tb_memory_access_stage.sv
module tb_memory_access_stage;
  import memory_access_stage_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       stall;
  logic       gnt;
  logic       rvalid;
  word_t      rdata;
  logic       dmem_req;
  logic       dmem_we;
  word_t      dmem_addr;
  word_t      dmem_wdata;
  logic [3:0] dmem_be;

  inst_packet_if ex_if ();
  inst_packet_if wb_if ();

  int errors = 0;
  int checks = 0;
  inst_packet_st exp_q[$];

  always #5 clk = ~clk;

  memory_access_stage #(.XLEN(32)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_flush          (flush),
    .i_stall          (stall),
    .if_execute_in    (ex_if),
    .if_writeback_out (wb_if),
    .o_dmem_req       (dmem_req),
    .o_dmem_we        (dmem_we),
    .o_dmem_addr      (dmem_addr),
    .o_dmem_wdata     (dmem_wdata),
    .o_dmem_be        (dmem_be),
    .i_dmem_gnt       (gnt),
    .i_dmem_rvalid    (rvalid),
    .i_dmem_rdata     (rdata)
  );

  // Standalone lane aligner
  logic [1:0] a_addr;
  mem_size_e  a_size;
  logic       a_uns;
  word_t      a_sdata;
  word_t      a_rdata;
  word_t      a_wdata;
  logic [3:0] a_be;
  word_t      a_ldata;
  logic       a_mis;

  mem_lane_align u_align (
    .i_addr_lo    (a_addr),
    .i_size       (a_size),
    .i_unsigned   (a_uns),
    .i_store_data (a_sdata),
    .i_rdata      (a_rdata),
    .o_wdata      (a_wdata),
    .o_be         (a_be),
    .o_load_data  (a_ldata),
    .o_misaligned (a_mis)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic inst_packet_st mk(input mem_op_e op, input mem_size_e sz, input logic uns,
                                       input word_t addr, input word_t sdata);
    inst_packet_st p;
    p = '0;
    p.pc                      = 32'h0000_1000;
    p.uop.mem_op              = op;
    p.uop.mem_size            = sz;
    p.uop.mem_unsigned        = uns;
    p.uop.rd_we               = 1'b1;
    p.uop.rd                  = 5'd7;
    p.alu_result              = addr;
    p.regfile_r_resp.r_data_2 = sdata;
    return p;
  endfunction

  // Scoreboard monitor: compares every packet handed to writeback.
  always @(negedge clk) begin : monitor
    inst_packet_st e;
    if (!rst && wb_if.valid === 1'b1 && wb_if.ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got packet alu_result 0x%0h, expected none",
                 wb_if.inst_packet.alu_result);
      end else begin
        e = exp_q.pop_front();
        chk("out_alu_result", wb_if.inst_packet.alu_result, e.alu_result);
        chk("out_load_data", wb_if.inst_packet.load_data, e.load_data);
        chk("out_trap", wb_if.inst_packet.trap, e.trap);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a packet to execute port and hold it until accepted.
  task automatic drive_pkt(input inst_packet_st p);
    bit ok;
    ok = 1'b0;
    ex_if.inst_packet = p;
    ex_if.valid       = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ex_if.ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got ready=0 for 50 cycles, expected acceptance");
    end
    @(posedge clk);
    #1;
    ex_if.valid = 1'b0;
  endtask

  // Wait for a request, check the bus fields, grant at once, answer one cycle later.
  task automatic serve_mem(input string tag, input logic exp_we, input word_t exp_addr,
                           input logic chk_wdata, input word_t exp_wdata,
                           input logic [3:0] exp_be, input word_t rd);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dmem_req === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_req_timeout: got no request, expected o_dmem_req", tag);
      return;
    end
    chk({tag, "_we"}, dmem_we, exp_we);
    chk({tag, "_addr"}, dmem_addr, exp_addr);
    if (chk_wdata) chk({tag, "_wdata"}, dmem_wdata, exp_wdata);
    chk({tag, "_be"}, dmem_be, exp_be);
    gnt = 1'b1;
    step();
    gnt    = 1'b0;
    rvalid = 1'b1;
    rdata  = rd;
    step();
    rvalid = 1'b0;
    rdata  = '0;
  endtask

  task automatic al_vec(input string name, input logic [1:0] addr, input mem_size_e sz,
                        input logic uns, input word_t sd, input word_t rd,
                        input word_t e_wdata, input logic [3:0] e_be, input logic chk_ld,
                        input word_t e_ld, input logic e_mis);
    a_addr  = addr;
    a_size  = sz;
    a_uns   = uns;
    a_sdata = sd;
    a_rdata = rd;
    #1;
    chk({name, "_wdata"}, a_wdata, e_wdata);
    chk({name, "_be"}, a_be, e_be);
    if (chk_ld) chk({name, "_ldata"}, a_ldata, e_ld);
    chk({name, "_mis"}, a_mis, e_mis);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no end of test by %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    inst_packet_st p;
    inst_packet_st e;
    inst_packet_st q;

    rst = 1'b1; flush = 1'b0; stall = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    ex_if.valid = 1'b0; ex_if.inst_packet = '0; wb_if.ready = 1'b1;
    a_addr = '0; a_size = WORD; a_uns = 1'b0; a_sdata = '0; a_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("reset_wb_valid", wb_if.valid, 1'b0);
    chk("reset_req", dmem_req, 1'b0);
    chk("reset_ex_ready", ex_if.ready, 1'b1);
    step();

    // ALU pass-through, 1-cycle latency, no bus request
    p = mk(NONE, WORD, 1'b0, 32'h0000_1234, 32'h0);
    exp_q.push_back(p);
    drive_pkt(p);
    @(negedge clk);
    chk("alu_latency_valid", wb_if.valid, 1'b1);
    chk("alu_no_req", dmem_req, 1'b0);
    step();

    // Stall blocks acceptance
    q = mk(NONE, WORD, 1'b0, 32'h0000_55AA, 32'h0);
    stall = 1'b1;
    ex_if.inst_packet = q;
    ex_if.valid = 1'b1;
    @(negedge clk);
    chk("stall_ready", ex_if.ready, 1'b0);
    step();
    stall = 1'b0;
    exp_q.push_back(q);
    drive_pkt(q);
    step();

    // LB at 0x103: byte lane 3, sign-extended
    p = mk(LOAD, BYTE, 1'b0, 32'h0000_0103, 32'h0);
    e = p; e.load_data = 32'hFFFF_FF80;
    exp_q.push_back(e);
    drive_pkt(p);
    serve_mem("lb", 1'b0, 32'h0000_0100, 1'b0, 32'h0, 4'b1000, 32'h80FF_FFFF);
    @(negedge clk);
    chk("lb_latency_valid", wb_if.valid, 1'b1);
    step();

    // LBU at 0x103: zero-extended
    p = mk(LOAD, BYTE, 1'b1, 32'h0000_0103, 32'h0);
    e = p; e.load_data = 32'h0000_0080;
    exp_q.push_back(e);
    drive_pkt(p);
    serve_mem("lbu", 1'b0, 32'h0000_0100, 1'b0, 32'h0, 4'b1000, 32'h80FF_FFFF);
    step();

    // SH at 0x202: upper half lanes, rdata ignored
    p = mk(STORE, HALF, 1'b0, 32'h0000_0202, 32'hABCD_1234);
    exp_q.push_back(p);
    drive_pkt(p);
    serve_mem("sh", 1'b1, 32'h0000_0200, 1'b1, 32'h1234_1234, 4'b1100, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("sh_forwarded_valid", wb_if.valid, 1'b1);
    step();

    // LW at 0x301: misaligned load trap, no request
    p = mk(LOAD, WORD, 1'b0, 32'h0000_0301, 32'h0);
    e = p; e.trap.valid = 1'b1; e.trap.cause = LOAD_ADDR_MISALIGNED; e.trap.tval = 32'h0000_0301;
    exp_q.push_back(e);
    drive_pkt(p);
    @(negedge clk);
    chk("lw_mis_valid", wb_if.valid, 1'b1);
    chk("lw_mis_no_req", dmem_req, 1'b0);
    step();

    // SH at 0x201: misaligned store trap
    p = mk(STORE, HALF, 1'b0, 32'h0000_0201, 32'h0000_9999);
    e = p; e.trap.valid = 1'b1; e.trap.cause = STORE_ADDR_MISALIGNED; e.trap.tval = 32'h0000_0201;
    exp_q.push_back(e);
    drive_pkt(p);
    @(negedge clk);
    chk("sh_mis_no_req", dmem_req, 1'b0);
    step();

    // LW at 0x400, gnt low for 3 cycles, flush in the 2nd: response dropped
    p = mk(LOAD, WORD, 1'b0, 32'h0000_0400, 32'h0);
    drive_pkt(p);
    @(negedge clk);
    chk("fl_req_c1", dmem_req, 1'b1);
    chk("fl_addr_c1", dmem_addr, 32'h0000_0400);
    step();
    flush = 1'b1;
    @(negedge clk);
    chk("fl_req_c2", dmem_req, 1'b1);
    chk("fl_addr_c2", dmem_addr, 32'h0000_0400);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("fl_req_c3", dmem_req, 1'b1);
    chk("fl_addr_c3", dmem_addr, 32'h0000_0400);
    chk("fl_wb_valid_c3", wb_if.valid, 1'b0);
    step();
    gnt = 1'b1;
    @(negedge clk);
    chk("fl_req_at_gnt", dmem_req, 1'b1);
    step();
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0000_0055;
    @(negedge clk);
    chk("fl_req_after_gnt", dmem_req, 1'b0);
    chk("fl_ready_waitdrop", ex_if.ready, 1'b0);
    chk("fl_wb_valid_rv", wb_if.valid, 1'b0);
    step();
    rvalid = 1'b0; rdata = '0;
    @(negedge clk);
    chk("fl_ready_after_rv", ex_if.ready, 1'b1);
    chk("fl_wb_valid_after", wb_if.valid, 1'b0);
    step();

    // Load completes while writeback is not ready: held, no new accept
    wb_if.ready = 1'b0;
    p = mk(LOAD, WORD, 1'b0, 32'h0000_0500, 32'h0);
    e = p; e.load_data = 32'hCAFE_F00D;
    exp_q.push_back(e);
    q = mk(NONE, WORD, 1'b0, 32'h0000_0777, 32'h0);
    exp_q.push_back(q);
    drive_pkt(p);
    serve_mem("lw_hold", 1'b0, 32'h0000_0500, 1'b0, 32'h0, 4'b1111, 32'hCAFE_F00D);
    ex_if.inst_packet = q;
    ex_if.valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_ex_ready", ex_if.ready, 1'b0);
      chk("hold_wb_valid", wb_if.valid, 1'b1);
    end
    step();
    wb_if.ready = 1'b1;
    drive_pkt(q);
    @(negedge clk);
    step();

    // Lane aligner standalone
    al_vec("al_lh",  2'd2, HALF, 1'b0, 32'h0000_BEEF, 32'h8001_0000,
           32'hBEEF_BEEF, 4'b1100, 1'b1, 32'hFFFF_8001, 1'b0);
    al_vec("al_lhu", 2'd2, HALF, 1'b1, 32'h0000_BEEF, 32'h8001_0000,
           32'hBEEF_BEEF, 4'b1100, 1'b1, 32'h0000_8001, 1'b0);
    al_vec("al_sb2", 2'd2, BYTE, 1'b0, 32'h1234_565A, 32'h00AB_0000,
           32'h5A5A_5A5A, 4'b0100, 1'b1, 32'hFFFF_FFAB, 1'b0);
    al_vec("al_lb1", 2'd1, BYTE, 1'b0, 32'h0000_0011, 32'h0000_7F00,
           32'h1111_1111, 4'b0010, 1'b1, 32'h0000_007F, 1'b0);
    al_vec("al_lw0", 2'd0, WORD, 1'b0, 32'hA5A5_0F0F, 32'h1234_5678,
           32'hA5A5_0F0F, 4'b1111, 1'b1, 32'h1234_5678, 1'b0);
    al_vec("al_w_mis", 2'd2, WORD, 1'b0, 32'hA5A5_0F0F, 32'h1234_5678,
           32'hA5A5_0F0F, 4'b1111, 1'b0, 32'h0, 1'b1);
    al_vec("al_h_mis", 2'd1, HALF, 1'b0, 32'h0000_1234, 32'h0,
           32'h1234_1234, 4'b0011, 1'b0, 32'h0, 1'b1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
